l2_write_buffer: RTL and testbench
==================================

// Module: l2_write_buffer
// PURPOSE
//  Posted write-back buffer between the L2 cache wishbone master and physical memory.
//  - Absorbs L2 dirty-line evictions with a 1-cycle ACK.
//  - Drains evictions to memory in the background.
//  - Services L2 line reads from buffered data on an address match; otherwise forwards them to memory.
//  - Single L2 requester, one outstanding request; memory side is a single wishbone slave.
// PARAMETERS
//  DEPTH  4  entries (power of 2, >=2); each entry = valid + 12b line addr + 128b line
// PORTS
//  clk        in   1    system clock (all logic on rising edge)
//  rst        in   1    synchronous, active-high reset
//  s_cyc      in   1    L2-side wishbone CYC
//  s_stb      in   1    L2-side STB; request = s_cyc & s_stb
//  s_we       in   1    1 = eviction write, 0 = line read
//  s_adr      in   12   line address (byte addr [15:4])
//  s_dat_i    in   128  eviction line data
//  s_sel      in   16   byte selects; ignored, full-line only
//  s_ack      out  1    one-cycle registered acknowledge to L2
//  s_dat_o    out  128  read line data, valid while s_ack=1
//  m_cyc      out  1    memory-side CYC (registered)
//  m_stb      out  1    memory-side STB, equal to m_cyc
//  m_we       out  1    memory write enable
//  m_adr      out  12   memory line address
//  m_dat_o    out  128  memory write data
//  m_sel      out  16   constant 16'hFFFF
//  m_ack      in   1    memory acknowledge
//  m_dat_i    in   128  memory read data, valid with m_ack
//  wbuf_hit   out  1    pulse: L2 read served from buffer
//  wbuf_empty out  1    1 when no valid entries
// BEHAVIOUR
//  Reset values:
//  - All entries invalid; head/tail/count = 0; FSM in IDLE.
//  - s_ack, m_cyc, m_stb, m_we, wbuf_hit = 0; wbuf_empty = 1; data/addr outputs = 0.
//  Storage: circular FIFO, head = oldest. Invariant: at most one valid entry per address.
//  FSM states: IDLE, WR_MEM (drain head), RD_MEM (read miss), RESP (s_ack cycle).
//  Acceptance: requests are accepted only in IDLE or WR_MEM, never in RESP, so the held STB is not re-accepted.
//  Write request, no match:
//  - Not full: push at tail; s_ack next cycle (via RESP when accepted from IDLE).
//  - Full: stall (no ack) until a slot frees.
//  - Pop and push in the same cycle are legal.
//  Write request, matching entry:
//  - Overwrite that entry's data in place (coalesce); 1-cycle ack.
//  - Exception: if the match is the head being drained (WR_MEM), stall until its m_ack pops it, then push.
//  Read request, match:
//  - Next cycle s_ack=1, s_dat_o = entry data, wbuf_hit=1; no memory access.
//  - Hits are allowed during WR_MEM; the drain continues.
//  Read request, miss:
//  - Wait for any in-flight drain's m_ack.
//  - Then RD_MEM: m_cyc=m_stb=1, m_we=0, m_adr=s_adr.
//  - On m_ack: latch m_dat_i, go to RESP, s_ack=1 for one cycle with the latched data.
//  - Latency = memory latency + 1.
//  Drain:
//  - Starts from IDLE when count>0 and no L2 read miss is pending; a read miss has priority over starting a drain.
//  - WR_MEM drives head addr/data with m_we=1.
//  - On m_ack: invalidate head, head++, count--. Next cycle: IDLE, then re-arbitrate.
//  Pointers: wrap modulo DEPTH; full = (count==DEPTH); wbuf_empty = (count==0).
//  Memory-side outputs: held stable for the whole transaction until m_ack; deasserted the cycle after m_ack.
//  Reset mid-operation: the in-flight memory transaction is abandoned; m_cyc drops next cycle; buffered lines are lost.
// STRUCTURE
//  lc3b_types additions:
//  - lc3b_line_addr (logic [11:0]), lc3b_line (logic [127:0]).
//  - wbuf_state_t enum {IDLE, WR_MEM, RD_MEM, RESP}.
//  Sub-module wbuf_cam (one natural split):
//  - Owns the entry array and FIFO pointers.
//  - Provides combinational match, match index, head entry, and push/pop/overwrite ports.
//  Top level holds the FSM and wishbone registers.
// TESTING
//  1. Reset, then eviction addr 0x010 data A -> s_ack 1 cycle later; the drain writes 0x010/A to memory; wbuf_empty returns to 1.
//  2. With memory ack withheld, 4 evictions 0x001-0x004 -> 4 acks; 5th (0x005) gets no ack until the first m_ack; FIFO order 1,2,3,4,5 at memory.
//  3. Eviction 0x020=A, then read 0x020 -> s_ack next cycle, data A, wbuf_hit=1, no m_cyc read.
//  4. Evictions 0x030=A then 0x030=B (not yet draining) -> one entry; memory sees a single write of B.
//  5. Read miss 0x040 during the drain of 0x010 -> read issued only after the drain ack; s_dat_o = memory data one cycle after m_ack.
//  6. rst asserted mid-WR_MEM -> next cycle m_cyc=0, wbuf_empty=1, s_ack=0.

Source files
------------

// File: rtl/l2_write_buffer_pkg.sv
// Shared types for the L2 posted write-back buffer.
// The line address/data typedefs mirror the LC-3b cache line layout.
package l2_write_buffer_pkg;

  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    WR_MEM,
    RD_MEM,
    RESP
  } wbuf_state_t;

  localparam int          WBUF_DEPTH = 4;
  localparam logic [15:0] FULL_SEL   = 16'hFFFF;

endpackage

// File: rtl/l2_write_buffer_if.sv
// Line-wide wishbone bus used on both sides of the write buffer.
// dat_w travels master->slave, dat_r travels slave->master.
interface l2_write_buffer_if;
  import l2_write_buffer_pkg::*;

  logic          cyc;
  logic          stb;
  logic          we;
  lc3b_line_addr adr;
  lc3b_line      dat_w;
  lc3b_line      dat_r;
  logic [15:0]   sel;
  logic          ack;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, dat_r
  );

endinterface

// File: rtl/l2_write_buffer_cam.sv
// Entry array plus FIFO pointers of the write buffer; fully associative lookup.
// Push and pop may hit the same slot when full: the push wins the valid bit.
module wbuf_cam
  import l2_write_buffer_pkg::*;
#(
  parameter  int DEPTH = WBUF_DEPTH,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  lc3b_line_addr lookup_addr_i,
  output logic          match_o,
  output logic [IW-1:0] match_idx_o,
  output lc3b_line      match_data_o,
  output logic [IW-1:0] head_idx_o,
  output lc3b_line_addr head_addr_o,
  output lc3b_line      head_data_o,
  output logic          full_o,
  output logic          empty_o,
  input  logic          push_i,
  input  lc3b_line_addr push_addr_i,
  input  lc3b_line      push_data_i,
  input  logic          pop_i,
  input  logic          ovr_i,
  input  logic [IW-1:0] ovr_idx_i,
  input  lc3b_line      ovr_data_i
);

  logic [DEPTH-1:0] valid_q;
  lc3b_line_addr    addr_q [DEPTH];
  lc3b_line         data_q [DEPTH];
  logic [IW-1:0]    head_q, tail_q;
  logic [IW:0]      count_q;

  always_comb begin
    match_o     = 1'b0;
    match_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr_i)) begin
        match_o     = 1'b1;
        match_idx_o = IW'(i);
      end
    end
  end

  assign match_data_o = data_q[match_idx_o];
  assign head_idx_o   = head_q;
  assign head_addr_o  = addr_q[head_q];
  assign head_data_o  = data_q[head_q];
  assign full_o       = (count_q == (IW+1)'(DEPTH));
  assign empty_o      = (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; validity alone decides what is buffered.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
    if (ovr_i) begin
      data_q[ovr_idx_i] <= ovr_data_i;
    end
  end

endmodule

// File: rtl/l2_write_buffer.sv
// Posted write-back buffer between the L2 wishbone master and memory.
// Evictions are absorbed and drained in the background; reads hit buffered lines.
module l2_write_buffer
  import l2_write_buffer_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  l2_write_buffer_if.slave    s,
  l2_write_buffer_if.master   m,
  output logic                wbuf_hit,
  output logic                wbuf_empty
);

  localparam int IW = $clog2(DEPTH);

  wbuf_state_t   state_q, state_d;
  logic          s_ack_q, s_ack_d;
  logic          hit_q, hit_d;
  lc3b_line      s_dat_q, s_dat_d;
  logic          m_cyc_q, m_cyc_d;
  logic          m_we_q, m_we_d;
  lc3b_line_addr m_adr_q, m_adr_d;
  lc3b_line      m_dat_q, m_dat_d;

  logic          match, full, empty;
  logic [IW-1:0] match_idx, head_idx;
  lc3b_line      match_data, head_data;
  lc3b_line_addr head_addr;
  logic          push, pop, ovr;
  logic          req, head_busy;
  logic          unused_sel;

  assign unused_sel = ^s.sel;

  wbuf_cam #(.DEPTH(DEPTH)) u_cam (
    .clk           (clk),
    .rst           (rst),
    .lookup_addr_i (s.adr),
    .match_o       (match),
    .match_idx_o   (match_idx),
    .match_data_o  (match_data),
    .head_idx_o    (head_idx),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .full_o        (full),
    .empty_o       (empty),
    .push_i        (push),
    .push_addr_i   (s.adr),
    .push_data_i   (s.dat_w),
    .pop_i         (pop),
    .ovr_i         (ovr),
    .ovr_idx_i     (match_idx),
    .ovr_data_i    (s.dat_w)
  );

  // The L2 still holds STB during its ack cycle; never accept it twice.
  assign req       = s.cyc & s.stb & ~s_ack_q;
  assign head_busy = (state_q == WR_MEM) & match & (match_idx == head_idx);

  always_comb begin
    state_d = state_q;
    s_ack_d = 1'b0;
    hit_d   = 1'b0;
    s_dat_d = s_dat_q;
    m_cyc_d = m_cyc_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && s.we && match) begin
          ovr     = 1'b1;
          s_ack_d = 1'b1;
          state_d = RESP;
        end else if (req && s.we && !full) begin
          push    = 1'b1;
          s_ack_d = 1'b1;
          state_d = RESP;
        end else if (req && !s.we && match) begin
          s_ack_d = 1'b1;
          hit_d   = 1'b1;
          s_dat_d = match_data;
          state_d = RESP;
        end else if (req && !s.we) begin
          m_cyc_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = s.adr;
          state_d = RD_MEM;
        end else if (!empty) begin
          m_cyc_d = 1'b1;
          m_we_d  = 1'b1;
          m_adr_d = head_addr;
          m_dat_d = head_data;
          state_d = WR_MEM;
        end
      end

      WR_MEM: begin
        if (m.ack) begin
          pop     = 1'b1;
          m_cyc_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = IDLE;
        end
        // A full buffer frees its head slot in the m_ack cycle itself.
        if (req && s.we) begin
          if (match && !head_busy) begin
            ovr     = 1'b1;
            s_ack_d = 1'b1;
          end else if (!match && (!full || m.ack)) begin
            push    = 1'b1;
            s_ack_d = 1'b1;
          end
        end else if (req && !s.we && match) begin
          s_ack_d = 1'b1;
          hit_d   = 1'b1;
          s_dat_d = match_data;
        end
      end

      RD_MEM: begin
        if (m.ack) begin
          s_ack_d = 1'b1;
          s_dat_d = m.dat_r;
          m_cyc_d = 1'b0;
          state_d = RESP;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_ack_q <= 1'b0;
      hit_q   <= 1'b0;
      s_dat_q <= '0;
      m_cyc_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
    end else begin
      state_q <= state_d;
      s_ack_q <= s_ack_d;
      hit_q   <= hit_d;
      s_dat_q <= s_dat_d;
      m_cyc_q <= m_cyc_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
    end
  end

  assign s.ack      = s_ack_q;
  assign s.dat_r    = s_dat_q;
  assign m.cyc      = m_cyc_q;
  assign m.stb      = m_cyc_q;
  assign m.we       = m_we_q;
  assign m.adr      = m_adr_q;
  assign m.dat_w    = m_dat_q;
  assign m.sel      = FULL_SEL;
  assign wbuf_hit   = hit_q;
  assign wbuf_empty = empty;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: memory writes and L2 read returns are
// checked against expectations queued when the stimulus is driven.
module tb_l2_write_buffer;
  import l2_write_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic wbuf_hit, wbuf_empty;

  l2_write_buffer_if l2_bus ();
  l2_write_buffer_if mem_bus ();

  l2_write_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .s          (l2_bus.slave),
    .m          (mem_bus.master),
    .wbuf_hit   (wbuf_hit),
    .wbuf_empty (wbuf_empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  lc3b_line_addr exp_wr_adr[$];
  lc3b_line      exp_wr_dat[$];
  lc3b_line      exp_rd_dat[$];
  bit            exp_rd_hit[$];

  bit mem_hold = 1'b0;
  int mem_lat  = 1;
  int n_mem_wr = 0;
  int n_mem_rd = 0;
  int wr_ack_cyc = 0;
  int rd_ack_cyc = 0;
  int rd_start_cyc = 0;
  bit rd_active = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic lc3b_line wpat(input lc3b_line_addr a, input logic [3:0] t);
    return {8{t, a}};
  endfunction

  function automatic lc3b_line rd_pat(input lc3b_line_addr a);
    return {8{4'h5, a}};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Memory slave: acks after mem_lat wait cycles unless held.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_bus.ack   = 1'b0;
    mem_bus.dat_r = '0;
    forever begin
      @(negedge clk);
      if (mem_bus.ack || rst) begin
        mem_bus.ack = 1'b0;
        wcnt = 0;
        if (rst) rd_active = 1'b0;
      end else begin
        if (mem_bus.cyc && !mem_bus.we && !rd_active) begin
          rd_active    = 1'b1;
          rd_start_cyc = cyc_n;
        end
        if (mem_bus.cyc && !mem_hold) begin
          if (wcnt >= mem_lat) begin
            mem_bus.ack = 1'b1;
            wcnt = 0;
            chk("m_stb", mem_bus.stb, 1);
            if (mem_bus.we) begin
              n_mem_wr++;
              wr_ack_cyc = cyc_n;
              if (exp_wr_adr.size() == 0) chk("mem_wr_unexp", exp_wr_adr.size(), 1);
              else begin
                chk("mem_wr_adr", mem_bus.adr, exp_wr_adr.pop_front());
                chk("mem_wr_dat", mem_bus.dat_w, exp_wr_dat.pop_front());
              end
            end else begin
              n_mem_rd++;
              rd_ack_cyc    = cyc_n;
              rd_active     = 1'b0;
              mem_bus.dat_r = rd_pat(mem_bus.adr);
            end
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  task automatic l2_start(input bit we, input lc3b_line_addr a, input lc3b_line d);
    @(negedge clk);
    l2_bus.cyc   = 1'b1;
    l2_bus.stb   = 1'b1;
    l2_bus.we    = we;
    l2_bus.adr   = a;
    l2_bus.dat_w = d;
  endtask

  task automatic l2_wait(input int max_cyc, output bit got, output int lat, output int ack_cyc);
    got = 1'b0; lat = 0; ack_cyc = 0;
    while (!got && lat < max_cyc) begin
      @(negedge clk);
      lat++;
      if (l2_bus.ack) begin
        got     = 1'b1;
        ack_cyc = cyc_n;
        if (!l2_bus.we) begin
          if (exp_rd_dat.size() == 0) chk("rd_unexp", exp_rd_dat.size(), 1);
          else begin
            chk("rd_dat", l2_bus.dat_r, exp_rd_dat.pop_front());
            chk("rd_hit", wbuf_hit, exp_rd_hit.pop_front());
          end
        end else begin
          chk("wr_hit", wbuf_hit, 0);
        end
        l2_bus.cyc = 1'b0;
        l2_bus.stb = 1'b0;
      end
    end
  endtask

  task automatic l2_req(input bit we, input lc3b_line_addr a, input lc3b_line d,
                        input int max_cyc, output bit got, output int lat);
    int ac;
    l2_start(we, a, d);
    l2_wait(max_cyc, got, lat, ac);
    if (!got) begin
      l2_bus.cyc = 1'b0;
      l2_bus.stb = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (exp_wr_adr.size() == 0 && wbuf_empty && !mem_bus.cyc) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_mcyc(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !mem_bus.cyc; i++) @(negedge clk);
    chk(tag, mem_bus.cyc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int lat, ack_cyc, base;
    rst = 1'b1;
    l2_bus.cyc = 1'b0; l2_bus.stb = 1'b0; l2_bus.we = 1'b0;
    l2_bus.adr = '0; l2_bus.dat_w = '0; l2_bus.sel = 16'hFFFF;
    repeat (3) @(negedge clk);

    chk("rst_s_ack", l2_bus.ack, 0);
    chk("rst_s_dat", l2_bus.dat_r, 0);
    chk("rst_m_cyc", mem_bus.cyc, 0);
    chk("rst_m_stb", mem_bus.stb, 0);
    chk("rst_m_we", mem_bus.we, 0);
    chk("rst_m_adr", mem_bus.adr, 0);
    chk("rst_m_dat", mem_bus.dat_w, 0);
    chk("rst_hit", wbuf_hit, 0);
    chk("rst_empty", wbuf_empty, 1);
    chk("m_sel", mem_bus.sel, 16'hFFFF);
    rst = 1'b0;

    // single eviction drains to memory
    exp_wr_adr.push_back(12'h010); exp_wr_dat.push_back(wpat(12'h010, 4'h1));
    l2_req(1'b1, 12'h010, wpat(12'h010, 4'h1), 10, got, lat);
    chk("t1_ack", got, 1);
    chk("t1_lat", lat, 1);
    wait_drain("t1_drain", 50);
    chk("t1_empty", wbuf_empty, 1);

    // fill with memory held; fifth eviction stalls until first m_ack
    mem_hold = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      exp_wr_adr.push_back(12'(a)); exp_wr_dat.push_back(wpat(12'(a), 4'h2));
      l2_req(1'b1, 12'(a), wpat(12'(a), 4'h2), 10, got, lat);
      chk("t2_ack", got, 1);
    end
    exp_wr_adr.push_back(12'h005); exp_wr_dat.push_back(wpat(12'h005, 4'h2));
    l2_start(1'b1, 12'h005, wpat(12'h005, 4'h2));
    l2_wait(8, got, lat, ack_cyc);
    chk("t2_full_stall", got, 0);
    base = n_mem_wr;
    mem_hold = 1'b0;
    l2_wait(30, got, lat, ack_cyc);
    chk("t2_ack5", got, 1);
    chk("t2_after_mack", n_mem_wr > base, 1);
    if (!got) begin l2_bus.cyc = 1'b0; l2_bus.stb = 1'b0; end
    wait_drain("t2_drain", 200);

    // read hit on a buffered line
    mem_hold = 1'b1;
    exp_wr_adr.push_back(12'h020); exp_wr_dat.push_back(wpat(12'h020, 4'hA));
    l2_req(1'b1, 12'h020, wpat(12'h020, 4'hA), 10, got, lat);
    base = n_mem_rd;
    exp_rd_dat.push_back(wpat(12'h020, 4'hA)); exp_rd_hit.push_back(1'b1);
    l2_req(1'b0, 12'h020, '0, 10, got, lat);
    chk("t3_ack", got, 1);
    chk("t3_lat", lat, 1);
    chk("t3_no_mem_rd", n_mem_rd, base);
    chk("t3_no_rd_cyc", rd_active, 0);
    mem_hold = 1'b0;
    wait_drain("t3_drain", 50);

    // coalescing: two evictions to 0x030 give one memory write of B
    mem_hold = 1'b1;
    base = n_mem_wr;
    exp_wr_adr.push_back(12'h031); exp_wr_dat.push_back(wpat(12'h031, 4'h3));
    l2_req(1'b1, 12'h031, wpat(12'h031, 4'h3), 10, got, lat);
    l2_req(1'b1, 12'h030, wpat(12'h030, 4'hA), 10, got, lat);
    chk("t4_ack_a", got, 1);
    exp_wr_adr.push_back(12'h030); exp_wr_dat.push_back(wpat(12'h030, 4'hB));
    l2_req(1'b1, 12'h030, wpat(12'h030, 4'hB), 10, got, lat);
    chk("t4_ack_b", got, 1);
    chk("t4_lat_b", lat, 1);
    mem_hold = 1'b0;
    wait_drain("t4_drain", 50);
    chk("t4_mem_writes", n_mem_wr - base, 2);

    // read miss waits for the in-flight drain
    mem_lat = 2;
    mem_hold = 1'b1;
    exp_wr_adr.push_back(12'h010); exp_wr_dat.push_back(wpat(12'h010, 4'hC));
    l2_req(1'b1, 12'h010, wpat(12'h010, 4'hC), 10, got, lat);
    wait_mcyc("t5_drain_start", 10);
    base = n_mem_rd;
    exp_rd_dat.push_back(rd_pat(12'h040)); exp_rd_hit.push_back(1'b0);
    l2_start(1'b0, 12'h040, '0);
    l2_wait(6, got, lat, ack_cyc);
    chk("t5_no_early_ack", got, 0);
    chk("t5_rd_held", rd_active, 0);
    mem_hold = 1'b0;
    l2_wait(40, got, lat, ack_cyc);
    chk("t5_ack", got, 1);
    if (!got) begin l2_bus.cyc = 1'b0; l2_bus.stb = 1'b0; end
    chk("t5_one_rd", n_mem_rd - base, 1);
    chk("t5_rd_after_drain", rd_start_cyc > wr_ack_cyc, 1);
    chk("t5_lat", ack_cyc - rd_ack_cyc, 1);
    wait_drain("t5_drain", 50);
    mem_lat = 1;

    // reset in the middle of a drain abandons it
    mem_hold = 1'b1;
    base = n_mem_wr;
    l2_req(1'b1, 12'h050, wpat(12'h050, 4'h6), 10, got, lat);
    wait_mcyc("t6_drain_start", 10);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_m_cyc", mem_bus.cyc, 0);
    chk("t6_empty", wbuf_empty, 1);
    chk("t6_s_ack", l2_bus.ack, 0);
    rst = 1'b0;
    mem_hold = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_write", n_mem_wr, base);
    chk("t6_still_empty", wbuf_empty, 1);

    chk("sb_wr_left", exp_wr_adr.size(), 0);
    chk("sb_rd_left", exp_rd_dat.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
